heptagon_result_drain: RTL and testbench
========================================

# heptagon_result_drain

Downstream stage of the heptagon area sorter. Captures the five-beat sorted burst (`valid`/`Index`/`Area`), checks it for ordering and index consistency, and accumulates the total area. It then re-emits the entries over a ready/valid handshake to a consumer that may stall. The upstream burst cannot be back-pressured, so the block fully buffers one batch.

## Interface
- `N_ENT`, default 5: entries per batch (heptagons per run).
- `AREA_W`, default 19: area width.
- `IDX_W`, default 3: index width.
- `SUM_W`, default 22: total-area width; holds N_ENT·(2^AREA_W−1) without overflow.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `in_valid` in 1: upstream `valid`; one entry per high cycle.
- `in_index` in IDX_W: upstream `Index`.
- `in_area` in AREA_W: upstream `Area`.
- `out_valid` out 1: entry available to the consumer.
- `out_ready` in 1: consumer accepts the entry when high together with `out_valid`.
- `out_index` out IDX_W: buffered index.
- `out_area` out AREA_W: buffered area.
- `out_rank` out IDX_W: position 0..N_ENT−1 within the batch.
- `out_last` out 1: high with the rank N_ENT−1 entry.
- `total_area` out SUM_W: sum of captured areas.
- `order_err` out 1: sticky; batch not in non-increasing area order.
- `idx_err` out 1: sticky; index ≥ N_ENT, or an index repeated within the batch.
- `ovf_err` out 1: sticky; `in_valid` arrived while draining.
- `busy` out 1: high in CAPTURE or DRAIN.

Reset values: every output is 0.

## Operation
- States:
  - IDLE: waiting for a batch.
  - CAPTURE: filling the buffer.
  - DRAIN: emitting to the consumer.
- IDLE + `in_valid`:
  - Clear `total_area`, `order_err`, `idx_err`, `ovf_err` and the seen-index mask.
  - Write the entry to slot 0; `total_area` ← `in_area`.
  - Go to CAPTURE with `wr_cnt`=1.
- CAPTURE + `in_valid`:
  - Write slot `wr_cnt`; `total_area` += `in_area`.
  - Set `order_err` if `in_area` > previous area (equal areas are legal).
  - Set `idx_err` if the index is ≥ N_ENT or its mask bit is already set; then set the mask bit.
  - At `wr_cnt`=N_ENT−1 go to DRAIN with `rd_ptr`=0.
- Gaps (`in_valid` low) inside CAPTURE are tolerated and produce no timeout.
- DRAIN:
  - `out_valid`=1; outputs show slot `rd_ptr`; `out_rank`=`rd_ptr`; `out_last`=(`rd_ptr`==N_ENT−1).
  - On `out_valid`&&`out_ready`, `rd_ptr`++.
  - After the last handshake, go to IDLE.
- `in_valid` in DRAIN, including the cycle of the last handshake: the entry is dropped and `ovf_err` is set.
- `total_area`, `order_err` and `idx_err` hold after DRAIN until the next batch's first entry.
- Arithmetic is unsigned, zero-extended to SUM_W. No saturation is needed.
- Slot 0's index also checks ≥ N_ENT and sets its mask bit.

## Timing
- Capture latency: an entry sampled at edge t is visible in the buffer and `total_area` after t.
- `out_valid` rises the cycle after the edge that captures the N_ENT-th entry.
- Throughput: one entry per cycle when `out_ready` is held high. A full drain takes N_ENT cycles.
- Outputs are registered or slot-muxed from registers. `out_*` is stable while `out_valid` && !`out_ready`.
- `out_valid` never drops without a handshake, except on reset.
- `busy` is high from the edge after the first capture until the edge after the last handshake.
- Reset mid-CAPTURE or mid-DRAIN returns to IDLE asynchronously. The partial batch is discarded and all flags are cleared.

## Structure
- Shared package `heptagon_pkg`:
  - `AREA_W`, `IDX_W`, `N_HEPT`=5, `SUM_W`.
  - State enum `drain_state_t` {IDLE, CAPTURE, DRAIN}.
- Sub-module `hept_entry_buf`:
  - N_ENT×(IDX_W+AREA_W) register file.
  - Write port: data, pointer, enable.
  - Combinational read port by `rd_ptr`.
- Top contains the FSM, counters, accumulator and checkers.

## Test plan
- Clean batch: areas 900,700,700,300,10 with indices 2,4,0,1,3 on consecutive cycles, `out_ready`=1.
  - Five beats in that order, `out_rank` 0..4, `out_last` on beat 5.
  - `total_area`=2610; all error flags 0.
- Back-pressure: same batch, `out_ready` toggling 1,0,0,1,….
  - Each entry is held stable while stalled; no loss or duplication.
- Order/index errors: areas 100,200,… → `order_err`=1. Indices 1,1,… → `idx_err`=1. Index 6 → `idx_err`=1.
  - The batch still drains fully.
- Overflow: assert `in_valid` during DRAIN, including the last-handshake cycle.
  - `ovf_err`=1; drained data is unchanged.
- Max values: five areas of 524287.
  - `total_area`=2621435 with no wrap.
  - A second batch clears the flags and sum at its first entry.
- Reset: assert `reset` mid-CAPTURE (after 3 entries) and mid-DRAIN.
  - All outputs 0 immediately; a following full batch drains correctly.

Source files
------------

// File: rtl/heptagon_pkg.sv
// rtl/heptagon_pkg.sv - shared widths and drain FSM state for the heptagon result path
package heptagon_pkg;
  localparam int AREA_W = 19;
  localparam int IDX_W  = 3;
  localparam int N_HEPT = 5;
  localparam int SUM_W  = 22;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } drain_state_t;
endpackage

// File: rtl/hept_entry_buf.sv
// rtl/hept_entry_buf.sv - one-batch register file of (index, area) entries
module hept_entry_buf #(
  parameter int N_ENT  = 5,
  parameter int IDX_W  = 3,
  parameter int AREA_W = 19,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [PTR_W-1:0]  wr_ptr_i,
  input  logic [IDX_W-1:0]  wr_index_i,
  input  logic [AREA_W-1:0] wr_area_i,
  input  logic [PTR_W-1:0]  rd_ptr_i,
  output logic [IDX_W-1:0]  rd_index_o,
  output logic [AREA_W-1:0] rd_area_o
);
  logic [IDX_W-1:0]  index_q [N_ENT];
  logic [AREA_W-1:0] area_q  [N_ENT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_ENT; i++) begin
        index_q[i] <= '0;
        area_q[i]  <= '0;
      end
    end else if (wr_en_i) begin
      for (int i = 0; i < N_ENT; i++) begin
        if (wr_ptr_i == PTR_W'(i)) begin
          index_q[i] <= wr_index_i;
          area_q[i]  <= wr_area_i;
        end
      end
    end
  end

  // Explicit mux keeps non-power-of-two depths free of out-of-range reads.
  always_comb begin
    rd_index_o = '0;
    rd_area_o  = '0;
    for (int i = 0; i < N_ENT; i++) begin
      if (rd_ptr_i == PTR_W'(i)) begin
        rd_index_o = index_q[i];
        rd_area_o  = area_q[i];
      end
    end
  end
endmodule

// File: rtl/heptagon_result_drain.sv
// rtl/heptagon_result_drain.sv - captures a sorted heptagon burst, checks it, and drains it over ready/valid
module heptagon_result_drain
  import heptagon_pkg::*;
#(
  parameter int N_ENT  = N_HEPT,
  parameter int AREA_W = heptagon_pkg::AREA_W,
  parameter int IDX_W  = heptagon_pkg::IDX_W,
  parameter int SUM_W  = heptagon_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_index,
  input  logic [AREA_W-1:0] in_area,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [AREA_W-1:0] out_area,
  output logic [IDX_W-1:0]  out_rank,
  output logic              out_last,
  output logic [SUM_W-1:0]  total_area,
  output logic              order_err,
  output logic              idx_err,
  output logic              ovf_err,
  output logic              busy
);
  localparam int PTR_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(N_ENT - 1);
  localparam logic [IDX_W:0]   N_ENT_X  = (IDX_W + 1)'(N_ENT);
  localparam logic [N_ENT-1:0] MASK_ONE = N_ENT'(1);

  drain_state_t      state_q, state_d;
  logic [PTR_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [SUM_W-1:0]  total_q, total_d;
  logic [AREA_W-1:0] prev_q, prev_d;
  logic [N_ENT-1:0]  mask_q, mask_d;
  logic              order_q, order_d;
  logic              idx_q, idx_d;
  logic              ovf_q, ovf_d;

  logic              wr_en;
  logic [PTR_W-1:0]  wr_ptr;
  logic              idx_bad;
  logic [N_ENT-1:0]  idx_bit;
  logic [IDX_W-1:0]  rd_index;
  logic [AREA_W-1:0] rd_area;

  hept_entry_buf #(
    .N_ENT (N_ENT),
    .IDX_W (IDX_W),
    .AREA_W(AREA_W),
    .PTR_W (PTR_W)
  ) u_buf (
    .clk       (clk),
    .rst       (reset),
    .wr_en_i   (wr_en),
    .wr_ptr_i  (wr_ptr),
    .wr_index_i(in_index),
    .wr_area_i (in_area),
    .rd_ptr_i  (rd_ptr_q),
    .rd_index_o(rd_index),
    .rd_area_o (rd_area)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      total_q  <= '0;
      prev_q   <= '0;
      mask_q   <= '0;
      order_q  <= 1'b0;
      idx_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      total_q  <= total_d;
      prev_q   <= prev_d;
      mask_q   <= mask_d;
      order_q  <= order_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_ptr_d  = rd_ptr_q;
    total_d   = total_q;
    prev_d    = prev_q;
    mask_d    = mask_q;
    order_d   = order_q;
    idx_d     = idx_q;
    ovf_d     = ovf_q;
    wr_en     = 1'b0;
    wr_ptr    = wr_cnt_q;
    out_valid = 1'b0;
    // Out-of-range indices shift out of the mask, so only the range test flags them.
    idx_bad   = ({1'b0, in_index} >= N_ENT_X);
    idx_bit   = MASK_ONE << in_index;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          wr_ptr   = '0;
          total_d  = SUM_W'(in_area);
          prev_d   = in_area;
          order_d  = 1'b0;
          ovf_d    = 1'b0;
          idx_d    = idx_bad;
          mask_d   = idx_bit;
          wr_cnt_d = PTR_W'(1);
          rd_ptr_d = '0;
          state_d  = (N_ENT == 1) ? DRAIN : CAPTURE;
        end
      end
      CAPTURE: begin
        if (in_valid) begin
          wr_en    = 1'b1;
          total_d  = total_q + SUM_W'(in_area);
          prev_d   = in_area;
          mask_d   = mask_q | idx_bit;
          wr_cnt_d = wr_cnt_q + PTR_W'(1);
          if (in_area > prev_q) order_d = 1'b1;
          if (idx_bad || ((mask_q & idx_bit) != '0)) idx_d = 1'b1;
          if (wr_cnt_q == LAST_PTR) begin
            state_d  = DRAIN;
            rd_ptr_d = '0;
            wr_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        if (in_valid) ovf_d = 1'b1;
        if (out_ready) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          if (rd_ptr_q == LAST_PTR) begin
            rd_ptr_d = '0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_index  = (state_q == DRAIN) ? rd_index : '0;
  assign out_area   = (state_q == DRAIN) ? rd_area : '0;
  assign out_rank   = (state_q == DRAIN) ? IDX_W'(rd_ptr_q) : '0;
  assign out_last   = (state_q == DRAIN) && (rd_ptr_q == LAST_PTR);
  assign total_area = total_q;
  assign order_err  = order_q;
  assign idx_err    = idx_q;
  assign ovf_err    = ovf_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_heptagon_result_drain.sv
// tb/tb_heptagon_result_drain.sv - directed self-checking bench for heptagon_result_drain
module tb_heptagon_result_drain;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_index;
  logic [18:0] in_area;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_index;
  logic [18:0] out_area;
  logic [2:0]  out_rank;
  logic        out_last;
  logic [21:0] total_area;
  logic        order_err, idx_err, ovf_err, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [18:0] b_area [5];
  logic [2:0]  b_idx  [5];
  logic [18:0] g_area [8];
  logic [2:0]  g_idx  [8];
  logic [2:0]  g_rank [8];
  logic        g_last [8];
  int          g_n, g_cycles, g_stall_changes;

  always #5 clk = ~clk;

  heptagon_result_drain dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_index  (in_index),
    .in_area   (in_area),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_area  (out_area),
    .out_rank  (out_rank),
    .out_last  (out_last),
    .total_area(total_area),
    .order_err (order_err),
    .idx_err   (idx_err),
    .ovf_err   (ovf_err),
    .busy      (busy)
  );

  task automatic set_batch(input int a0, a1, a2, a3, a4, input int i0, i1, i2, i3, i4);
    b_area[0] = 19'(a0); b_area[1] = 19'(a1); b_area[2] = 19'(a2);
    b_area[3] = 19'(a3); b_area[4] = 19'(a4);
    b_idx[0] = 3'(i0); b_idx[1] = 3'(i1); b_idx[2] = 3'(i2);
    b_idx[3] = 3'(i3); b_idx[4] = 3'(i4);
  endtask

  task automatic send_batch(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      in_valid = 1'b1;
      in_index = b_idx[i];
      in_area  = b_area[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_index = '0;
    in_area  = '0;
  endtask

  // junk: 0 none, 1 every drain cycle, 2 only on the final handshake cycle
  task automatic collect(input bit bp, input int junk);
    logic [24:0] snap;
    bit          stalled;
    g_n = 0; g_cycles = 0; g_stall_changes = 0; stalled = 0; snap = '0;
    while (g_n < 5 && g_cycles < 40) begin
      out_ready = bp ? (g_cycles % 3 == 0) : 1'b1;
      in_valid  = (junk == 1) || (junk == 2 && g_n == 4 && out_ready);
      in_index  = 3'd7;
      in_area   = 19'h7ffff;
      if (stalled && (!out_valid || {out_index, out_area, out_rank} != snap)) g_stall_changes++;
      stalled = 0;
      if (out_valid && out_ready) begin
        g_idx[g_n] = out_index; g_area[g_n] = out_area;
        g_rank[g_n] = out_rank; g_last[g_n] = out_last;
        g_n++;
      end else if (out_valid) begin
        stalled = 1;
        snap = {out_index, out_area, out_rank};
      end
      @(posedge clk); #1;
      g_cycles++;
    end
    out_ready = 1'b0; in_valid = 1'b0; in_index = '0; in_area = '0;
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 0; in_index = 0; in_area = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({out_valid, busy, total_area, order_err, idx_err, ovf_err, out_index, out_area, out_rank, out_last} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got total=%0d valid=%b busy=%b flags=%b%b%b want all 0",
                         total_area, out_valid, busy, order_err, idx_err, ovf_err);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean;
    set_batch(900, 700, 700, 300, 10, 2, 4, 0, 1, 3);
    send_batch(0, 0);
    n_cmp++;
    if ({busy, out_valid, total_area} !== {1'b1, 1'b0, 22'd900}) begin
      n_fail++; $display("FAIL clean_first: busy=%b valid=%b total=%0d want 1 0 900", busy, out_valid, total_area);
    end
    send_batch(1, 4);
    n_cmp++;
    if ({out_valid, total_area} !== {1'b1, 22'd2610}) begin
      n_fail++; $display("FAIL clean_captured: valid=%b total=%0d want 1 2610", out_valid, total_area);
    end
    collect(1'b0, 0);
    n_cmp++;
    if (g_n !== 5 || g_cycles !== 5) begin
      n_fail++; $display("FAIL clean_count: beats=%0d cycles=%0d want 5 5", g_n, g_cycles);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({g_idx[k], g_area[k], g_rank[k], g_last[k]} !== {b_idx[k], b_area[k], 3'(k), (k == 4)}) begin
        n_fail++; $display("FAIL clean_beat%0d: idx=%0d area=%0d rank=%0d last=%b want %0d %0d %0d %b",
                           k, g_idx[k], g_area[k], g_rank[k], g_last[k], b_idx[k], b_area[k], k, k == 4);
      end
    end
    n_cmp++;
    if ({busy, out_valid, order_err, idx_err, ovf_err, total_area} !== {5'b0, 22'd2610}) begin
      n_fail++; $display("FAIL clean_after: busy=%b valid=%b flags=%b%b%b total=%0d want 0 0 000 2610",
                         busy, out_valid, order_err, idx_err, ovf_err, total_area);
    end
  endtask

  task automatic test_backpressure;
    set_batch(900, 700, 700, 300, 10, 2, 4, 0, 1, 3);
    send_batch(0, 4);
    collect(1'b1, 0);
    n_cmp++;
    if (g_n !== 5 || g_stall_changes !== 0) begin
      n_fail++; $display("FAIL bp_count: beats=%0d stall_changes=%0d want 5 0", g_n, g_stall_changes);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({g_idx[k], g_area[k], g_rank[k], g_last[k]} !== {b_idx[k], b_area[k], 3'(k), (k == 4)}) begin
        n_fail++; $display("FAIL bp_beat%0d: idx=%0d area=%0d rank=%0d last=%b want %0d %0d %0d %b",
                           k, g_idx[k], g_area[k], g_rank[k], g_last[k], b_idx[k], b_area[k], k, k == 4);
      end
    end
  endtask

  task automatic test_errors;
    set_batch(100, 200, 50, 40, 30, 0, 1, 2, 3, 4);
    send_batch(0, 4);
    n_cmp++;
    if ({order_err, idx_err, total_area} !== {2'b10, 22'd420}) begin
      n_fail++; $display("FAIL err_order: order=%b idx=%b total=%0d want 1 0 420", order_err, idx_err, total_area);
    end
    collect(1'b0, 0);
    n_cmp++;
    if (g_n !== 5 || g_area[1] !== 19'd200 || g_last[4] !== 1'b1) begin
      n_fail++; $display("FAIL err_order_drain: beats=%0d area1=%0d last4=%b want 5 200 1", g_n, g_area[1], g_last[4]);
    end
    set_batch(500, 400, 300, 200, 100, 1, 1, 2, 3, 4);
    send_batch(0, 4);
    n_cmp++;
    if ({order_err, idx_err} !== 2'b01) begin
      n_fail++; $display("FAIL err_dup: order=%b idx=%b want 0 1", order_err, idx_err);
    end
    collect(1'b0, 0);
    n_cmp++;
    if (g_n !== 5 || g_idx[1] !== 3'd1) begin
      n_fail++; $display("FAIL err_dup_drain: beats=%0d idx1=%0d want 5 1", g_n, g_idx[1]);
    end
    set_batch(60, 50, 40, 30, 20, 6, 0, 1, 2, 3);
    send_batch(0, 0);
    n_cmp++;
    if ({order_err, idx_err} !== 2'b01) begin
      n_fail++; $display("FAIL err_range_slot0: order=%b idx=%b want 0 1", order_err, idx_err);
    end
    send_batch(1, 4);
    collect(1'b0, 0);
    n_cmp++;
    if (g_n !== 5 || g_idx[0] !== 3'd6 || idx_err !== 1'b1) begin
      n_fail++; $display("FAIL err_range_drain: beats=%0d idx0=%0d idx_err=%b want 5 6 1", g_n, g_idx[0], idx_err);
    end
  endtask

  task automatic test_overflow;
    set_batch(900, 700, 700, 300, 10, 2, 4, 0, 1, 3);
    send_batch(0, 4);
    n_cmp++;
    if (ovf_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pre: ovf=%b want 0", ovf_err);
    end
    collect(1'b0, 2);
    n_cmp++;
    if ({ovf_err, busy, out_valid, total_area} !== {3'b100, 22'd2610}) begin
      n_fail++; $display("FAIL ovf_last_hs: ovf=%b busy=%b valid=%b total=%0d want 1 0 0 2610",
                         ovf_err, busy, out_valid, total_area);
    end
    send_batch(0, 4);
    collect(1'b0, 1);
    n_cmp++;
    if ({ovf_err, order_err, idx_err, g_n} !== {3'b100, 32'd5}) begin
      n_fail++; $display("FAIL ovf_all: ovf=%b order=%b idx=%b beats=%0d want 1 0 0 5", ovf_err, order_err, idx_err, g_n);
    end
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({g_idx[k], g_area[k]} !== {b_idx[k], b_area[k]}) begin
        n_fail++; $display("FAIL ovf_beat%0d: idx=%0d area=%0d want %0d %0d", k, g_idx[k], g_area[k], b_idx[k], b_area[k]);
      end
    end
  endtask

  task automatic test_max;
    set_batch(524287, 524287, 524287, 524287, 524287, 4, 3, 2, 1, 0);
    send_batch(0, 4);
    n_cmp++;
    if ({total_area, order_err, idx_err} !== {22'd2621435, 2'b00}) begin
      n_fail++; $display("FAIL max_total: total=%0d order=%b idx=%b want 2621435 0 0", total_area, order_err, idx_err);
    end
    collect(1'b0, 1);
    n_cmp++;
    if (g_n !== 5 || g_area[4] !== 19'd524287 || ovf_err !== 1'b1) begin
      n_fail++; $display("FAIL max_drain: beats=%0d area4=%0d ovf=%b want 5 524287 1", g_n, g_area[4], ovf_err);
    end
    set_batch(7, 6, 5, 4, 3, 0, 1, 2, 3, 4);
    send_batch(0, 0);
    n_cmp++;
    if ({total_area, ovf_err} !== {22'd7, 1'b0}) begin
      n_fail++; $display("FAIL max_second_first: total=%0d ovf=%b want 7 0", total_area, ovf_err);
    end
    send_batch(1, 4);
    collect(1'b0, 0);
    n_cmp++;
    if (total_area !== 22'd25 || g_n !== 5 || g_area[0] !== 19'd7) begin
      n_fail++; $display("FAIL max_second: total=%0d beats=%0d area0=%0d want 25 5 7", total_area, g_n, g_area[0]);
    end
  endtask

  task automatic test_reset_mid;
    set_batch(900, 700, 700, 300, 10, 2, 4, 0, 1, 3);
    send_batch(0, 2);
    n_cmp++;
    if ({busy, total_area} !== {1'b1, 22'd2300}) begin
      n_fail++; $display("FAIL rst_cap_pre: busy=%b total=%0d want 1 2300", busy, total_area);
    end
    reset = 1'b1; #1;
    n_cmp++;
    if ({out_valid, busy, total_area, order_err, idx_err, ovf_err, out_index, out_area, out_rank, out_last} !== '0) begin
      n_fail++; $display("FAIL rst_cap: busy=%b valid=%b total=%0d want 0 0 0", busy, out_valid, total_area);
    end
    @(posedge clk); #1; reset = 1'b0;
    set_batch(80, 70, 60, 50, 40, 4, 3, 2, 1, 0);
    send_batch(0, 4);
    collect(1'b0, 0);
    n_cmp++;
    if (g_n !== 5 || total_area !== 22'd300 || g_area[2] !== 19'd60 || g_idx[0] !== 3'd4) begin
      n_fail++; $display("FAIL rst_cap_after: beats=%0d total=%0d area2=%0d idx0=%0d want 5 300 60 4",
                         g_n, total_area, g_area[2], g_idx[0]);
    end
    send_batch(0, 4);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, out_rank, out_area} !== {1'b1, 3'd1, 19'd70}) begin
      n_fail++; $display("FAIL rst_drn_pre: valid=%b rank=%0d area=%0d want 1 1 70", out_valid, out_rank, out_area);
    end
    reset = 1'b1; #1;
    n_cmp++;
    if ({out_valid, busy, total_area, order_err, idx_err, ovf_err, out_index, out_area, out_rank, out_last} !== '0) begin
      n_fail++; $display("FAIL rst_drn: busy=%b valid=%b total=%0d rank=%0d want 0 0 0 0", busy, out_valid, total_area, out_rank);
    end
    @(posedge clk); #1; reset = 1'b0;
    set_batch(900, 700, 700, 300, 10, 2, 4, 0, 1, 3);
    send_batch(0, 4);
    collect(1'b0, 0);
    n_cmp++;
    if (g_n !== 5 || total_area !== 22'd2610 || g_rank[0] !== 3'd0 || g_area[0] !== 19'd900) begin
      n_fail++; $display("FAIL rst_drn_after: beats=%0d total=%0d rank0=%0d area0=%0d want 5 2610 0 900",
                         g_n, total_area, g_rank[0], g_area[0]);
    end
  endtask

  initial begin
    test_reset;
    test_clean;
    test_backpressure;
    test_errors;
    test_overflow;
    test_max;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
